// File: rtl/sdram_init_ctrl_if.sv
// Signal bundle between the SDRAM init sequencer and the pin-side command mux.
// The master is the sequencer; the slave is whatever consumes the command stream.
interface sdram_init_ctrl_if;
    logic        power_ok;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        init_busy;
    logic        init_done;

    modport master (
        input  power_ok,
        output cmd,
        output ba,
        output addr,
        output init_busy,
        output init_done
    );

    modport slave (
        output power_ok,
        input  cmd,
        input  ba,
        input  addr,
        input  init_busy,
        input  init_done
    );
endinterface

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: stabilisation wait, PRECHARGE-ALL,
// REF_NUM AUTO-REFRESHes, LOAD MODE REGISTER, then a sticky init_done.
module sdram_init_ctrl #(
    parameter int          WAIT_PWR = 20000,
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          T_MRD    = 2,
    parameter int          REF_NUM  = 8,
    parameter logic [12:0] MODE_REG = 13'h037
) (
    input logic              clk,
    input logic              rst,
    sdram_init_ctrl_if.master sdram
);

    localparam int MAX_A   = (WAIT_PWR > T_RFC) ? WAIT_PWR : T_RFC;
    localparam int MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_W   = $clog2(REF_NUM + 1);

    localparam logic [CNT_W-1:0] C_WAIT_END = CNT_W'(WAIT_PWR - 1);
    localparam logic [CNT_W-1:0] C_RP_END   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] C_RFC_END  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] C_MRD_END  = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] C_REF_LAST = REF_W'(REF_NUM - 1);

    localparam logic [3:0]  CMD_NOP = 4'b0111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_MRS = 4'b0000;
    localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;

    // Each command state covers its own command cycle plus the tRP/tRFC/tMRD gap after it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_REF,
        S_MRS,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REF_W-1:0]  r_refCnt;
    logic [3:0]        r_cmd;
    logic [1:0]        r_ba;
    logic [12:0]       r_addr;
    logic              r_busy;
    logic              r_done;

    state_t            w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [REF_W-1:0]  w_refCnt;
    logic [3:0]        w_cmd;
    logic [1:0]        w_ba;
    logic [12:0]       w_addr;
    logic              w_busy;
    logic              w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_refCnt <= '0;
            r_cmd    <= CMD_NOP;
            r_ba     <= '0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_refCnt <= w_refCnt;
            r_cmd    <= w_cmd;
            r_ba     <= w_ba;
            r_addr   <= w_addr;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Outputs are computed for the next cycle so the pins come straight from flops.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_refCnt = r_refCnt;
        w_cmd    = CMD_NOP;
        w_ba     = 2'b00;
        w_addr   = '0;
        w_busy   = r_busy;
        w_done   = r_done;

        case (r_state)
            S_IDLE: begin
                if (sdram.power_ok) begin
                    w_state = S_WAIT;
                    w_cnt   = '0;
                    w_busy  = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_DONE;
            end
            default: begin
                // Losing power mid-sequence abandons everything; a later rise starts over.
                if (!sdram.power_ok) begin
                    w_state  = S_IDLE;
                    w_cnt    = '0;
                    w_refCnt = '0;
                    w_busy   = 1'b0;
                end else begin
                    case (r_state)
                        S_WAIT: begin
                            if (r_cnt == C_WAIT_END) begin
                                w_state = S_PRE;
                                w_cnt   = '0;
                                w_cmd   = CMD_PRE;
                                w_addr  = ADDR_ALL_BANKS;
                            end else begin
                                w_cnt = r_cnt + 1'b1;
                            end
                        end
                        S_PRE: begin
                            if (r_cnt == C_RP_END) begin
                                w_state  = S_REF;
                                w_cnt    = '0;
                                w_refCnt = '0;
                                w_cmd    = CMD_REF;
                            end else begin
                                w_cnt = r_cnt + 1'b1;
                            end
                        end
                        S_REF: begin
                            if (r_cnt == C_RFC_END) begin
                                w_cnt = '0;
                                if (r_refCnt == C_REF_LAST) begin
                                    w_state = S_MRS;
                                    w_cmd   = CMD_MRS;
                                    w_addr  = MODE_REG;
                                end else begin
                                    w_refCnt = r_refCnt + 1'b1;
                                    w_cmd    = CMD_REF;
                                end
                            end else begin
                                w_cnt = r_cnt + 1'b1;
                            end
                        end
                        S_MRS: begin
                            if (r_cnt == C_MRD_END) begin
                                w_state = S_DONE;
                                w_cnt   = '0;
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                            end else begin
                                w_cnt = r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            w_state = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign sdram.cmd       = r_cmd;
    assign sdram.ba        = r_ba;
    assign sdram.addr      = r_addr;
    assign sdram.init_busy = r_busy;
    assign sdram.init_done = r_done;

endmodule
